// File: rtl/bus_pkg.sv
// Shared data-bus request/response types used by every initiator and slave on bus_intercon.
package bus;

  typedef struct packed {
    logic        stb;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } m2s_s;

  typedef struct packed {
    logic        ack;
    logic [31:0] rdata;
  } s2m_s;

endpackage

// File: rtl/dma_pkg.sv
// Types and helpers for the word-copy DMA master.
package dma_pkg;

  typedef enum logic [2:0] {IDLE, RD, WR, FIN, ERR} dma_state_e;

  localparam int unsigned MAX_BURST = 16;

  // Words in the next phase: the burst size, or fewer when the block is almost done.
  function automatic logic [4:0] burst_len(input logic [15:0] rem, input int unsigned burst);
    if (rem < 16'(burst)) begin
      return rem[4:0];
    end
    return 5'(burst);
  endfunction

endpackage

// File: rtl/dma_burst_buf.sv
// Burst staging buffer: one synchronous write port, one asynchronous read port.
module dma_burst_buf #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PW    = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [PW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/bus_dma_master.sv
// Word-copy DMA initiator: reads up to BURST words into a buffer, writes them out, repeats.
module bus_dma_master
  import dma_pkg::*;
#(
  parameter int unsigned BURST   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [31:0] src_addr_i,
  input  logic [31:0] dst_addr_i,
  input  logic [15:0] len_words_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output bus::m2s_s   bus_o,
  input  bus::s2m_s   bus_i
);

  localparam int unsigned PW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  dma_state_e    state_q;
  logic [31:0]   src_q, dst_q, addr_q, wdata_q;
  logic [15:0]   rem_q;
  logic [4:0]    idx_q, blen_q;
  logic [TW-1:0] tmo_q;
  logic          busy_q, done_q, err_q, stb_q, we_q;

  logic          buf_we;
  logic [PW-1:0] buf_raddr;
  logic [31:0]   buf_rdata;
  logic          last_beat, timeout_hit;

  assign buf_we      = (state_q == RD) && bus_i.ack;
  // Reads land at idx; writes need the entry after the one currently on the bus.
  assign buf_raddr   = (state_q == RD) ? '0 : PW'(idx_q + 5'd1);
  assign last_beat   = (idx_q + 5'd1) == blen_q;
  assign timeout_hit = stb_q && !bus_i.ack && (tmo_q == TMO_LAST);

  dma_burst_buf #(
    .DEPTH(BURST),
    .PW   (PW)
  ) u_buf (
    .clk  (clk),
    .we   (buf_we),
    .waddr(idx_q[PW-1:0]),
    .wdata(bus_i.rdata),
    .raddr(buf_raddr),
    .rdata(buf_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rem_q   <= '0;
      idx_q   <= '0;
      blen_q  <= '0;
      tmo_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (stb_q && !bus_i.ack) begin
        tmo_q <= tmo_q + TW'(1);
      end
      if (timeout_hit) begin
        // Abandon the stuck request; buffered data is simply dropped.
        state_q <= ERR;
        err_q   <= 1'b1;
        done_q  <= 1'b1;
        stb_q   <= 1'b0;
        we_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_i) begin
              src_q  <= src_addr_i;
              dst_q  <= dst_addr_i;
              rem_q  <= len_words_i;
              blen_q <= burst_len(len_words_i, BURST);
              idx_q  <= '0;
              tmo_q  <= '0;
              err_q  <= 1'b0;
              busy_q <= 1'b1;
              if (len_words_i == 16'd0) begin
                state_q <= FIN;
                done_q  <= 1'b1;
              end else begin
                state_q <= RD;
                stb_q   <= 1'b1;
                we_q    <= 1'b0;
                addr_q  <= src_addr_i;
              end
            end
          end
          RD: begin
            if (bus_i.ack) begin
              tmo_q <= '0;
              src_q <= src_q + 32'd4;
              if (last_beat) begin
                state_q <= WR;
                idx_q   <= '0;
                we_q    <= 1'b1;
                addr_q  <= dst_q;
                // A single-word phase has not reached the buffer yet.
                wdata_q <= (idx_q == 5'd0) ? bus_i.rdata : buf_rdata;
              end else begin
                idx_q  <= idx_q + 5'd1;
                addr_q <= src_q + 32'd4;
              end
            end
          end
          WR: begin
            if (bus_i.ack) begin
              tmo_q <= '0;
              dst_q <= dst_q + 32'd4;
              rem_q <= rem_q - 16'd1;
              if (last_beat) begin
                idx_q <= '0;
                if (rem_q == 16'd1) begin
                  state_q <= FIN;
                  done_q  <= 1'b1;
                  stb_q   <= 1'b0;
                  we_q    <= 1'b0;
                end else begin
                  state_q <= RD;
                  we_q    <= 1'b0;
                  addr_q  <= src_q;
                  blen_q  <= burst_len(rem_q - 16'd1, BURST);
                end
              end else begin
                idx_q   <= idx_q + 5'd1;
                addr_q  <= dst_q + 32'd4;
                wdata_q <= buf_rdata;
              end
            end
          end
          FIN, ERR: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign bus_o.stb   = stb_q;
  assign bus_o.we    = we_q;
  assign bus_o.addr  = addr_q;
  assign bus_o.wdata = wdata_q;
  assign bus_o.be    = {4{we_q}};

endmodule

// File: tb/tb_bus_dma_master.sv
// Scoreboard bench for bus_dma_master against a simple 4 KiB slave; addresses >= 4 KiB never ack.
module tb_bus_dma_master;

  localparam int unsigned BURST   = 4;
  localparam int unsigned TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i;
  logic [31:0] src_addr_i, dst_addr_i;
  logic [15:0] len_words_i;
  logic        busy_o, done_o, err_o;
  bus::m2s_s   bus_o;
  bus::s2m_s   bus_i;

  bus_dma_master #(
    .BURST  (BURST),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .src_addr_i (src_addr_i),
    .dst_addr_i (dst_addr_i),
    .len_words_i(len_words_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .bus_o      (bus_o),
    .bus_i      (bus_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model
  logic [31:0] mem [1024];
  logic        stall = 1'b0;
  logic        stall_en;

  always_comb begin
    bus_i.ack   = bus_o.stb && (bus_o.addr < 32'h0000_1000) && !stall;
    bus_i.rdata = mem[bus_o.addr[11:2]];
  end

  always @(posedge clk) begin
    stall <= stall_en ? ~stall : 1'b0;
    if (bus_o.stb && bus_o.we && bus_i.ack) mem[bus_o.addr[11:2]] <= bus_o.wdata;
  end

  function automatic logic [31:0] pat(input logic [31:0] a);
    return 32'hA500_0000 ^ (a * 32'h0001_0003);
  endfunction

  // Scoreboard
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t exp_q[$];
  bit   exp_done_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   stb_cycles = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push_copy(input logic [31:0] src, input logic [31:0] dst, input int len);
    int          rem;
    int          n;
    logic [31:0] s, d;
    rem = len;
    s   = src;
    d   = dst;
    while (rem > 0) begin
      n = (rem < BURST) ? rem : BURST;
      for (int i = 0; i < n; i++) exp_q.push_back(txn_t'{1'b0, s + 32'(4 * i), 32'd0});
      for (int i = 0; i < n; i++) exp_q.push_back(txn_t'{1'b1, d + 32'(4 * i), pat(s + 32'(4 * i))});
      s   = s + 32'(4 * n);
      d   = d + 32'(4 * n);
      rem = rem - n;
    end
    exp_done_q.push_back(1'b0);
  endtask

  // Monitor
  txn_t      mon_t;
  bit        mon_e;
  bit        hold_v = 1'b0;
  bus::m2s_s held;

  always @(negedge clk) begin
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (bus_o.stb) stb_cycles++;
      if (bus_o.stb && bus_i.ack) begin
        if (exp_q.size() == 0) begin
          check("txn_pending", exp_q.size(), 1);
        end else begin
          mon_t = exp_q.pop_front();
          check("txn_we", bus_o.we, mon_t.we);
          check("txn_addr", bus_o.addr, mon_t.addr);
          if (mon_t.we) begin
            check("txn_wdata", bus_o.wdata, mon_t.data);
            check("txn_be", bus_o.be, 4'hF);
          end
        end
      end
      if (done_o) begin
        if (exp_done_q.size() == 0) begin
          check("done_pending", exp_done_q.size(), 1);
        end else begin
          mon_e = exp_done_q.pop_front();
          check("done_err", err_o, mon_e);
        end
      end
      if (hold_v && !done_o) begin
        check("hold_stb", bus_o.stb, held.stb);
        check("hold_we", bus_o.we, held.we);
        check("hold_addr", bus_o.addr, held.addr);
        check("hold_wdata", bus_o.wdata, held.wdata);
      end
      hold_v = bus_o.stb && !bus_i.ack;
      held   = bus_o;
    end
  end

  task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    @(negedge clk);
    start_i     = 1'b1;
    src_addr_i  = s;
    dst_addr_i  = d;
    len_words_i = n;
    @(posedge clk);
    #1;
    start_i     = 1'b0;
    src_addr_i  = 32'hDEAD_BEEF;
    dst_addr_i  = 32'hBAAD_F00D;
    len_words_i = 16'hFFFF;
  endtask

  task automatic wait_done(input int budget, output bit ok, output int at);
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (done_o) begin
        ok = 1'b1;
        at = cyc;
      end
    end
  endtask

  task automatic wait_write_req(input int budget, output bit ok, output int at);
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (bus_o.stb && bus_o.we) begin
        ok = 1'b1;
        at = cyc;
      end
    end
  endtask

  initial begin
    bit ok;
    int c0, dc, cw, s0;
    start_i     = 1'b0;
    src_addr_i  = '0;
    dst_addr_i  = '0;
    len_words_i = '0;
    stall_en    = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] <= pat(32'(i * 4));

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    check("rst_stb", bus_o.stb, 0);
    check("rst_we", bus_o.we, 0);
    check("rst_addr", bus_o.addr, 0);
    check("rst_wdata", bus_o.wdata, 0);
    @(negedge clk);
    rst = 1'b0;

    // 10 words, phases 4/4/2, slave acks every cycle
    push_copy(32'h0, 32'h100, 10);
    start_copy(32'h0, 32'h100, 16'd10);
    c0 = cyc;
    check("t1_busy_n1", busy_o, 1);
    check("t1_stb_n1", bus_o.stb, 1);
    wait_done(100, ok, dc);
    check("t1_done_seen", ok, 1);
    check("t1_cycles", dc - c0, 20);
    @(posedge clk);
    #1;
    check("t1_done_once", done_o, 0);
    check("t1_busy_off", busy_o, 0);
    check("t1_err", err_o, 0);
    for (int i = 0; i < 10; i++) check("t1_mem", mem[64 + i], pat(32'(4 * i)));
    check("t1_mem_beyond", mem[74], pat(32'h128));

    // Zero length: done at N+1, no request
    exp_done_q.push_back(1'b0);
    s0 = stb_cycles;
    start_copy(32'h10, 32'h20, 16'd0);
    check("t2_done_n1", done_o, 1);
    check("t2_busy_n1", busy_o, 1);
    check("t2_stb_n1", bus_o.stb, 0);
    @(posedge clk);
    #1;
    check("t2_busy_n2", busy_o, 0);
    check("t2_done_n2", done_o, 0);
    check("t2_no_stb", stb_cycles - s0, 0);

    // Unmapped destination times out
    exp_q.push_back(txn_t'{1'b0, 32'h0, 32'd0});
    exp_q.push_back(txn_t'{1'b0, 32'h4, 32'd0});
    exp_done_q.push_back(1'b1);
    start_copy(32'h0, 32'h8000_0000, 16'd2);
    wait_write_req(50, ok, cw);
    check("t3_wr_req_seen", ok, 1);
    wait_done(50, ok, dc);
    check("t3_done_seen", ok, 1);
    check("t3_tmo_cycles", dc - cw, TIMEOUT);
    check("t3_err_at_done", err_o, 1);
    check("t3_stb_dropped", bus_o.stb, 0);
    @(posedge clk);
    #1;
    check("t3_err_sticky", err_o, 1);
    check("t3_busy_off", busy_o, 0);
    push_copy(32'h10, 32'h3C0, 1);
    start_copy(32'h10, 32'h3C0, 16'd1);
    check("t3_err_cleared", err_o, 0);
    wait_done(50, ok, dc);
    check("t3b_done_seen", ok, 1);
    check("t3b_mem", mem[32'h3C0 >> 2], pat(32'h10));

    // Start while busy is ignored; slave stalls every other cycle
    stall_en = 1'b1;
    push_copy(32'h40, 32'h200, 5);
    start_copy(32'h40, 32'h200, 16'd5);
    repeat (3) @(posedge clk);
    start_copy(32'h300, 32'h380, 16'd3);
    wait_done(200, ok, dc);
    check("t4_done_seen", ok, 1);
    stall_en = 1'b0;
    @(posedge clk);
    #1;
    check("t4_busy_off", busy_o, 0);
    for (int i = 0; i < 5; i++) check("t4_mem", mem[128 + i], pat(32'h40 + 32'(4 * i)));
    check("t4_mem_untouched", mem[32'h380 >> 2], pat(32'h380));

    // Reset between edges during WR
    push_copy(32'h80, 32'h240, 6);
    start_copy(32'h80, 32'h240, 16'd6);
    wait_write_req(50, ok, cw);
    check("t5_wr_req_seen", ok, 1);
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_stb", bus_o.stb, 0);
    check("t5_rst_we", bus_o.we, 0);
    check("t5_rst_addr", bus_o.addr, 0);
    check("t5_rst_busy", busy_o, 0);
    check("t5_rst_done", done_o, 0);
    check("t5_rst_err", err_o, 0);
    exp_q.delete();
    exp_done_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t5_idle_busy", busy_o, 0);
    check("t5_mem_not_written", mem[32'h240 >> 2], pat(32'h240));
    push_copy(32'h0, 32'h300, 3);
    start_copy(32'h0, 32'h300, 16'd3);
    wait_done(100, ok, dc);
    check("t5_done_seen", ok, 1);
    check("t5_err", err_o, 0);
    for (int i = 0; i < 3; i++) check("t5_mem", mem[192 + i], pat(32'(4 * i)));

    repeat (5) @(posedge clk);
    #1;
    check("sb_txn_left", exp_q.size(), 0);
    check("sb_done_left", exp_done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
